// File: rtl/testname_pkg.sv
// Shared constants for the testname control/status block: register map,
// ID value, CTRL bit positions and CMP reset value.
package testname_pkg;

    localparam logic [9:0]  ADDR_ID      = 10'h000;
    localparam logic [9:0]  ADDR_CTRL    = 10'h004;
    localparam logic [9:0]  ADDR_SCRATCH = 10'h008;
    localparam logic [9:0]  ADDR_COUNT   = 10'h00C;
    localparam logic [9:0]  ADDR_STAT    = 10'h010;
    localparam logic [9:0]  ADDR_CMP     = 10'h014;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t    IDX_ID       = ADDR_ID[4:2];
    localparam reg_idx_t    IDX_CTRL     = ADDR_CTRL[4:2];
    localparam reg_idx_t    IDX_SCRATCH  = ADDR_SCRATCH[4:2];
    localparam reg_idx_t    IDX_COUNT    = ADDR_COUNT[4:2];
    localparam reg_idx_t    IDX_STAT     = ADDR_STAT[4:2];
    localparam reg_idx_t    IDX_CMP      = ADDR_CMP[4:2];
    localparam reg_idx_t    IDX_LIMIT    = 3'd6;

    localparam logic [31:0] ID_VALUE     = 32'h7E57_0001;
    localparam logic [31:0] CMP_RESET    = 32'hFFFF_FFFF;

    localparam int          CTRL_EN      = 32'd0;
    localparam int          CTRL_IRQ_EN  = 32'd1;
    localparam int          CTRL_CLR     = 32'd2;
    localparam int          STAT_MATCH   = 32'd0;

endpackage

// File: rtl/testname_apb_if.sv
// APB phase decoder: produces write/read strobes, the word index and the
// registered error response shown during the access phase.
module testname_apb_if
    import testname_pkg::*;
#(
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [AWIDTH-1:0] paddr_i,
    output logic              wr_en_o,
    output logic              rd_en_o,
    output reg_idx_t          addr_idx_o,
    output logic              mapped_o,
    output logic              pslverr_o
);

    logic setup_s;
    logic access_s;
    logic err_s;
    logic pslverr_d;
    logic pslverr_q;

    // Phase and address decode; the error flag is captured at setup so it is stable for the whole access phase
    always_comb begin
        setup_s    = psel_i & ~penable_i;
        access_s   = psel_i & penable_i;
        addr_idx_o = paddr_i[4:2];
        mapped_o   = (paddr_i[AWIDTH-1:5] == '0) && (paddr_i[4:2] < IDX_LIMIT);
        err_s      = ~mapped_o | (pwrite_i & ((addr_idx_o == IDX_ID) | (addr_idx_o == IDX_COUNT)));
        wr_en_o    = access_s & pwrite_i & ~err_s;
        rd_en_o    = setup_s & ~pwrite_i;
        pslverr_d  = setup_s & err_s;
    end

    // Error response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= pslverr_d;
        end
    end

    assign pslverr_o = pslverr_q;

endmodule

// File: rtl/testname_regs.sv
// Register bank, free-running counter and compare-match interrupt for the
// testname function, attached to APB as a zero-wait-state slave.
module testname_regs
    import testname_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [AWIDTH-1:0] paddr,
    input  logic [DWIDTH-1:0] pwdata,
    output logic [DWIDTH-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              irq
);

    logic              wr_en_s;
    logic              rd_en_s;
    reg_idx_t          addr_idx_s;
    logic              mapped_s;

    logic              wr_ctrl_s;
    logic              wr_scratch_s;
    logic              wr_stat_s;
    logic              wr_cmp_s;
    logic              match_set_s;

    logic              en_d,       en_q;
    logic              irq_en_d,   irq_en_q;
    logic [DWIDTH-1:0] scratch_d,  scratch_q;
    logic [DWIDTH-1:0] count_d,    count_q;
    logic [DWIDTH-1:0] cmp_d,      cmp_q;
    logic              match_d,    match_q;
    logic [DWIDTH-1:0] prdata_d,   prdata_q;

    testname_apb_if #(.AWIDTH(AWIDTH)) u_apb_if (
        .clk        (clk),
        .rst_n      (rst_n),
        .psel_i     (psel),
        .penable_i  (penable),
        .pwrite_i   (pwrite),
        .paddr_i    (paddr),
        .wr_en_o    (wr_en_s),
        .rd_en_o    (rd_en_s),
        .addr_idx_o (addr_idx_s),
        .mapped_o   (mapped_s),
        .pslverr_o  (pslverr)
    );

    // Next-state logic for the register bank, counter, match flag and read data
    always_comb begin
        wr_ctrl_s    = wr_en_s & (addr_idx_s == IDX_CTRL);
        wr_scratch_s = wr_en_s & (addr_idx_s == IDX_SCRATCH);
        wr_stat_s    = wr_en_s & (addr_idx_s == IDX_STAT);
        wr_cmp_s     = wr_en_s & (addr_idx_s == IDX_CMP);
        match_set_s  = en_q & (count_q == cmp_q);

        en_d      = en_q;
        irq_en_d  = irq_en_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        cmp_d     = cmp_q;
        match_d   = match_q;
        prdata_d  = prdata_q;

        if (wr_ctrl_s) begin
            en_d     = pwdata[CTRL_EN];
            irq_en_d = pwdata[CTRL_IRQ_EN];
        end else begin
            en_d     = en_q;
            irq_en_d = irq_en_q;
        end

        if (wr_scratch_s) begin
            scratch_d = pwdata;
        end else begin
            scratch_d = scratch_q;
        end

        if (wr_cmp_s) begin
            cmp_d = pwdata;
        end else begin
            cmp_d = cmp_q;
        end

        // CLR beats increment; the counter compares its pre-increment value
        if (wr_ctrl_s && pwdata[CTRL_CLR]) begin
            count_d = '0;
        end else if (en_q) begin
            count_d = count_q + DWIDTH'(1'b1);
        end else begin
            count_d = count_q;
        end

        if (match_set_s) begin
            match_d = 1'b1;
        end else if (wr_stat_s && pwdata[STAT_MATCH]) begin
            match_d = 1'b0;
        end else begin
            match_d = match_q;
        end

        if (rd_en_s && mapped_s) begin
            case (addr_idx_s)
                IDX_ID:      prdata_d = DWIDTH'(ID_VALUE);
                IDX_CTRL:    prdata_d = {{(DWIDTH-2){1'b0}}, irq_en_q, en_q};
                IDX_SCRATCH: prdata_d = scratch_q;
                IDX_COUNT:   prdata_d = count_q;
                IDX_STAT:    prdata_d = {{(DWIDTH-1){1'b0}}, match_q};
                IDX_CMP:     prdata_d = cmp_q;
                default:     prdata_d = '0;
            endcase
        end else if (rd_en_s) begin
            prdata_d = '0;
        end else begin
            prdata_d = prdata_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            scratch_q <= '0;
            count_q   <= '0;
            cmp_q     <= DWIDTH'(CMP_RESET);
            match_q   <= 1'b0;
            prdata_q  <= '0;
        end else begin
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
            match_q   <= match_d;
            prdata_q  <= prdata_d;
        end
    end

    assign prdata = prdata_q;
    assign pready = 1'b1;
    assign irq    = irq_en_q & match_q;

endmodule

// File: tb/tb_testname_regs.sv
// Directed bench for testname_regs: register access, counter/compare
// interrupt timing, error responses and reset during a write.
module tb_testname_regs;
    import testname_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        err;

    testname_regs #(.DWIDTH(32), .AWIDTH(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is just after a rising edge; returns just after the access edge.
    task automatic apb_write(input logic [9:0] addr, input logic [31:0] data, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        e = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [9:0] addr, output logic [31:0] data, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        data = prdata;
        e    = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 10'h000; pwdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_prdata",  prdata,         32'h0);
        check("rst_pslverr", {31'h0, pslverr}, 32'h0);
        check("rst_irq",     {31'h0, irq},     32'h0);
        check("rst_pready",  {31'h0, pready},  32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        apb_read(ADDR_ID, rd, err);
        check("id", rd, 32'h7E57_0001);
        check("id_err", {31'h0, err}, 32'h0);
        apb_read(ADDR_SCRATCH, rd, err); check("scratch_rst", rd, 32'h0);
        apb_read(ADDR_COUNT, rd, err);   check("count_rst",   rd, 32'h0);
        apb_read(ADDR_CMP, rd, err);     check("cmp_rst",     rd, 32'hFFFF_FFFF);
        apb_read(ADDR_CTRL, rd, err);    check("ctrl_rst",    rd, 32'h0);
        apb_read(ADDR_STAT, rd, err);    check("stat_rst",    rd, 32'h0);

        apb_write(ADDR_SCRATCH, 32'hA5A5_5A5A, err);
        check("scratch_wr_err", {31'h0, err}, 32'h0);
        apb_read(ADDR_SCRATCH, rd, err);
        check("scratch_rd", rd, 32'hA5A5_5A5A);
        check("scratch_rd_err", {31'h0, err}, 32'h0);

        // Counter starts the edge after the CTRL access edge: COUNT==10 after 10 more edges, irq one edge later
        apb_write(ADDR_CMP, 32'd10, err);
        apb_write(ADDR_CTRL, 32'd3, err);
        check("irq_start", {31'h0, irq}, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        check("irq_at_cnt10", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        check("irq_rise", {31'h0, irq}, 32'h1);
        apb_read(ADDR_COUNT, rd, err);
        check("count_past_cmp", rd, 32'd11);
        apb_read(ADDR_STAT, rd, err);
        check("stat_match", rd, 32'h1);
        apb_write(ADDR_STAT, 32'h1, err);
        check("irq_clear", {31'h0, irq}, 32'h0);
        apb_read(ADDR_STAT, rd, err);
        check("stat_cleared", rd, 32'h0);

        apb_write(ADDR_CTRL, 32'd5, err);
        apb_read(ADDR_COUNT, rd, err);
        check("count_clr", rd, 32'h0);
        apb_read(ADDR_CTRL, rd, err);
        check("ctrl_rb", rd, 32'h1);
        apb_write(ADDR_CTRL, 32'd0, err);
        apb_read(ADDR_COUNT, rd, err);
        check("count_stopped", rd, 32'd6);

        apb_write(ADDR_COUNT, 32'h0000_1234, err);
        check("wr_count_err", {31'h0, err}, 32'h1);
        apb_read(ADDR_COUNT, rd, err);
        check("count_unaffected", rd, 32'd6);
        check("count_rd_err", {31'h0, err}, 32'h0);
        apb_write(10'h020, 32'hDEAD_BEEF, err);
        check("wr_unmapped_err", {31'h0, err}, 32'h1);
        apb_write(10'h028, 32'h0, err);
        check("wr_alias_err", {31'h0, err}, 32'h1);
        apb_read(ADDR_SCRATCH, rd, err);
        check("scratch_no_alias", rd, 32'hA5A5_5A5A);
        apb_read(10'h3FC, rd, err);
        check("rd_unmapped_data", rd, 32'h0);
        check("rd_unmapped_err", {31'h0, err}, 32'h1);
        apb_write(ADDR_ID, 32'h0, err);
        check("wr_id_err", {31'h0, err}, 32'h1);
        apb_read(ADDR_ID, rd, err);
        check("id_after_wr", rd, 32'h7E57_0001);
        check("pready", {31'h0, pready}, 32'h1);

        // Reset during the access phase of a SCRATCH write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = ADDR_SCRATCH; pwdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_pslverr", {31'h0, pslverr}, 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_read(ADDR_SCRATCH, rd, err);
        check("scratch_after_rst", rd, 32'h0);
        apb_read(ADDR_CMP, rd, err);
        check("cmp_after_rst", rd, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
